// File: rtl/gyro_bias_cal_pkg.sv
// Shared types, widths and the 17-to-16-bit saturating helper for the gyro bias stage.
package gyro_pkg;

  localparam int GYRO_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_LATCH,
    ST_CALIBRATED
  } gyro_cal_state_t;

  // Overflow is visible as a disagreement between the two top bits of the 17-bit difference.
  function automatic logic signed [GYRO_W-1:0] sat16(input logic signed [GYRO_W:0] v);
    if (v[GYRO_W] != v[GYRO_W-1]) begin
      return v[GYRO_W] ? {1'b1, {(GYRO_W-1){1'b0}}} : {1'b0, {(GYRO_W-1){1'b1}}};
    end
    return v[GYRO_W-1:0];
  endfunction

endpackage

// File: rtl/gyro_bias_cal_if.sv
// Sample/calibration bus between the I2C reader, the bias stage and the integrator.
interface gyro_bias_cal_if
  import gyro_pkg::*;
  ;

  logic                     valid_in;
  logic signed [GYRO_W-1:0] gx_in;
  logic signed [GYRO_W-1:0] gy_in;
  logic signed [GYRO_W-1:0] gz_in;
  logic                     cal_start_in;

  logic signed [GYRO_W-1:0] gx_out;
  logic signed [GYRO_W-1:0] gy_out;
  logic signed [GYRO_W-1:0] gz_out;
  logic                     valid_out;
  logic signed [GYRO_W-1:0] bias_x_out;
  logic signed [GYRO_W-1:0] bias_y_out;
  logic signed [GYRO_W-1:0] bias_z_out;
  logic                     calibrating_out;
  logic                     cal_done_out;

  modport master (
    output valid_in, gx_in, gy_in, gz_in, cal_start_in,
    input  gx_out, gy_out, gz_out, valid_out,
    input  bias_x_out, bias_y_out, bias_z_out, calibrating_out, cal_done_out
  );

  modport slave (
    input  valid_in, gx_in, gy_in, gz_in, cal_start_in,
    output gx_out, gy_out, gz_out, valid_out,
    output bias_x_out, bias_y_out, bias_z_out, calibrating_out, cal_done_out
  );

endinterface

// File: rtl/gyro_bias_cal_axis.sv
// One gyro axis: calibration accumulator, committed bias and registered saturated correction.
// Optional deadband on the corrected output is enabled by defining GYRO_DEADBAND_EN.
module gyro_axis_cal
  import gyro_pkg::*;
#(
  parameter int unsigned LOG2_SAMPLES = 10
`ifdef GYRO_DEADBAND_EN
  ,
  parameter int unsigned DEADBAND = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [GYRO_W-1:0] sample_in,
  input  logic                     acc_clr,
  input  logic                     acc_en,
  input  logic                     latch,
  output logic signed [GYRO_W-1:0] corr_out,
  output logic signed [GYRO_W-1:0] bias_out
);

  localparam int unsigned ACC_W = GYRO_W + LOG2_SAMPLES;

  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_shift;
  logic signed [GYRO_W-1:0] bias_q, bias_d, corr_q, corr_d, sat_val;
  logic signed [GYRO_W:0]   diff;
`ifdef GYRO_DEADBAND_EN
  localparam logic signed [GYRO_W:0] DB = (GYRO_W+1)'(DEADBAND);
  logic signed [GYRO_W:0] sat_ext;
`endif

  always_comb begin
    acc_shift = acc_q >>> LOG2_SAMPLES;
    diff      = {sample_in[GYRO_W-1], sample_in} - {bias_q[GYRO_W-1], bias_q};
    sat_val   = sat16(diff);

    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + {{LOG2_SAMPLES{sample_in[GYRO_W-1]}}, sample_in};
    end

    bias_d = latch ? acc_shift[GYRO_W-1:0] : bias_q;

    corr_d = corr_q;
`ifdef GYRO_DEADBAND_EN
    sat_ext = {sat_val[GYRO_W-1], sat_val};
    if (valid_in) begin
      corr_d = ((sat_ext <= DB) && (sat_ext >= -DB)) ? '0 : sat_val;
    end
`else
    if (valid_in) begin
      corr_d = sat_val;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
      corr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      corr_q <= corr_d;
    end
  end

  assign corr_out = corr_q;
  assign bias_out = bias_q;

endmodule

// File: rtl/gyro_bias_cal.sv
// Gyro zero-rate calibration and bias removal: FSM and sample counter, three axis slices.
// Optional output deadband is enabled by defining GYRO_DEADBAND_EN.
module gyro_bias_cal
  import gyro_pkg::*;
#(
  parameter int unsigned LOG2_SAMPLES = 10,
  parameter int unsigned DEADBAND     = 8
) (
  input logic           clk_in,
  input logic           rst_n_in,
  gyro_bias_cal_if.slave bus
);

  gyro_cal_state_t         state_q, state_d;
  logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    acc_clr, acc_en, latch;

  // The counter is exactly LOG2_SAMPLES wide: all-ones marks the final sample of the batch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CALIBRATED: begin
        if (bus.cal_start_in) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (bus.cal_start_in) begin
          cnt_d   = '0;
          acc_clr = 1'b1;
        end else if (bus.valid_in) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (bus.cal_start_in) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end else begin
          latch   = 1'b1;
          state_d = ST_CALIBRATED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d  = latch;
    valid_d = bus.valid_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.valid_out       = valid_q;
  assign bus.cal_done_out    = done_q;
  assign bus.calibrating_out = (state_q == ST_ACCUM) || (state_q == ST_LATCH);

`ifdef GYRO_DEADBAND_EN
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES), .DEADBAND(DEADBAND)) u_axis_x (
`else
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_x (
`endif
    .clk(clk_in), .rst_n(rst_n_in), .valid_in(bus.valid_in), .sample_in(bus.gx_in),
    .acc_clr(acc_clr), .acc_en(acc_en), .latch(latch),
    .corr_out(bus.gx_out), .bias_out(bus.bias_x_out)
  );

`ifdef GYRO_DEADBAND_EN
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES), .DEADBAND(DEADBAND)) u_axis_y (
`else
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_y (
`endif
    .clk(clk_in), .rst_n(rst_n_in), .valid_in(bus.valid_in), .sample_in(bus.gy_in),
    .acc_clr(acc_clr), .acc_en(acc_en), .latch(latch),
    .corr_out(bus.gy_out), .bias_out(bus.bias_y_out)
  );

`ifdef GYRO_DEADBAND_EN
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES), .DEADBAND(DEADBAND)) u_axis_z (
`else
  gyro_axis_cal #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_z (
`endif
    .clk(clk_in), .rst_n(rst_n_in), .valid_in(bus.valid_in), .sample_in(bus.gz_in),
    .acc_clr(acc_clr), .acc_en(acc_en), .latch(latch),
    .corr_out(bus.gz_out), .bias_out(bus.bias_z_out)
  );

endmodule

// File: tb/tb_gyro_bias_cal.sv
// Bench for gyro_bias_cal with LOG2_SAMPLES = 2: behavioural model plus literal spot checks.
module tb_gyro_bias_cal;
  import gyro_pkg::*;

  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  gyro_bias_cal_if bus ();

  gyro_bias_cal #(.LOG2_SAMPLES(L)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model state: committed bias, samples gathered so far, pending mean awaiting commit.
  int exp_g[3]    = '{0, 0, 0};
  int bias[3]     = '{0, 0, 0};
  int pend_bias[3];
  int smp[3][$];
  bit collecting  = 1'b0;
  bit pend        = 1'b0;
  bit exp_valid   = 1'b0;
  bit exp_done    = 1'b0;
  bit exp_cal     = 1'b0;

  function automatic int corr(input int v, input int b);
    int d;
    d = v - b;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
`ifdef GYRO_DEADBAND_EN
    if (d <= DB && d >= -DB) d = 0;
`endif
    return d;
  endfunction

  function automatic int floor_mean(input int s);
    int q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int in_v[3];
    int s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_g = '{0, 0, 0};
        bias  = '{0, 0, 0};
        for (int a = 0; a < 3; a++) smp[a].delete();
        collecting = 1'b0;
        pend       = 1'b0;
        exp_valid  = 1'b0;
        exp_done   = 1'b0;
        exp_cal    = 1'b0;
      end else begin
        in_v[0] = int'(bus.gx_in);
        in_v[1] = int'(bus.gy_in);
        in_v[2] = int'(bus.gz_in);
        exp_valid = bus.valid_in;
        if (bus.valid_in)
          for (int a = 0; a < 3; a++) exp_g[a] = corr(in_v[a], bias[a]);
        exp_done = 1'b0;
        if (bus.cal_start_in) begin
          collecting = 1'b1;
          pend = 1'b0;
          for (int a = 0; a < 3; a++) smp[a].delete();
        end else if (pend) begin
          bias = pend_bias;
          pend = 1'b0;
          exp_done = 1'b1;
        end else if (collecting && bus.valid_in) begin
          for (int a = 0; a < 3; a++) smp[a].push_back(in_v[a]);
          if (smp[0].size() == N) begin
            for (int a = 0; a < 3; a++) begin
              s = 0;
              foreach (smp[a][k]) s += smp[a][k];
              pend_bias[a] = floor_mean(s);
            end
            pend = 1'b1;
            collecting = 1'b0;
          end
        end
        exp_cal = collecting || pend;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("valid_out", {31'd0, bus.valid_out}, int'(exp_valid));
      chk("cal_done_out", {31'd0, bus.cal_done_out}, int'(exp_done));
      chk("calibrating_out", {31'd0, bus.calibrating_out}, int'(exp_cal));
      chk("bias_x", bus.bias_x_out, bias[0]);
      chk("bias_y", bus.bias_y_out, bias[1]);
      chk("bias_z", bus.bias_z_out, bias[2]);
      if (exp_valid) begin
        chk("gx_out", bus.gx_out, exp_g[0]);
        chk("gy_out", bus.gy_out, exp_g[1]);
        chk("gz_out", bus.gz_out, exp_g[2]);
      end
    end
  end

  task automatic apply(input bit v, input int x, input int y, input int z, input bit s);
    bus.valid_in     = v;
    bus.gx_in        = 16'(x);
    bus.gy_in        = 16'(y);
    bus.gz_in        = 16'(z);
    bus.cal_start_in = s;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.gx_in = '0;
    bus.gy_in = '0;
    bus.gz_in = '0;
    bus.cal_start_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid_out", {31'd0, bus.valid_out}, 0);
    chk("rst gx_out", bus.gx_out, 0);
    chk("rst bias_x", bus.bias_x_out, 0);
    chk("rst calibrating", {31'd0, bus.calibrating_out}, 0);
    rst_n = 1'b1;
    idle();

    // Pass-through with zero bias, back to back.
    apply(1'b1, 100, -50, 0, 1'b0);
    chk("pass valid", {31'd0, bus.valid_out}, 1);
    chk("pass gx", bus.gx_out, 100);
    chk("pass gy", bus.gy_out, -50);
    chk("pass gz", bus.gz_out, 0);
    apply(1'b1, -7, 32767, -32768, 1'b0);
    idle();

    // Calibration; coincident sample is not accumulated.
    apply(1'b1, 555, 555, 555, 1'b1);
    apply(1'b1, 10, -1, 100, 1'b0);
    apply(1'b1, 12, -1, 100, 1'b0);
    apply(1'b1, 14, -1, 100, 1'b0);
    apply(1'b1, 16, -2, 100, 1'b0);
    chk("latch calibrating", {31'd0, bus.calibrating_out}, 1);
    chk("latch no done", {31'd0, bus.cal_done_out}, 0);
    idle();
    chk("cal done", {31'd0, bus.cal_done_out}, 1);
    chk("cal bias_x", bus.bias_x_out, 13);
    chk("cal bias_y", bus.bias_y_out, -2);
    chk("cal bias_z", bus.bias_z_out, 100);
    apply(1'b1, 20, 0, -32768, 1'b0);
    chk("done one cycle", {31'd0, bus.cal_done_out}, 0);
`ifdef GYRO_DEADBAND_EN
    chk("corr gx 7", bus.gx_out, 0);
`else
    chk("corr gx 7", bus.gx_out, 7);
`endif
    chk("sat low gz", bus.gz_out, -32768);
    apply(1'b1, 21, 0, 0, 1'b0);
`ifdef GYRO_DEADBAND_EN
    chk("band 8", bus.gx_out, 0);
`else
    chk("band 8", bus.gx_out, 8);
`endif
    apply(1'b1, 22, 0, 0, 1'b0);
    chk("band 9", bus.gx_out, 9);
    idle();

    // Restart in ACCUM after 2 samples, then restart in LATCH.
    apply(1'b0, 0, 0, 0, 1'b1);
    apply(1'b1, 0, 0, -100, 1'b0);
    apply(1'b1, 0, 0, -100, 1'b0);
    apply(1'b0, 0, 0, 0, 1'b1);
    repeat (3) apply(1'b1, 0, 0, -100, 1'b0);
    chk("restart still cal", {31'd0, bus.calibrating_out}, 1);
    chk("restart bias kept", bus.bias_z_out, 100);
    apply(1'b1, 0, 0, -100, 1'b0);
    apply(1'b1, 0, 0, 5000, 1'b1);
    chk("latch restart no done", {31'd0, bus.cal_done_out}, 0);
    chk("latch restart bias", bus.bias_z_out, 100);
    chk("latch sample old bias", bus.gz_out, 4900);
    repeat (4) apply(1'b1, 4, 0, -100, 1'b0);
    idle();
    chk("recal done", {31'd0, bus.cal_done_out}, 1);
    chk("recal bias_z", bus.bias_z_out, -100);
    chk("recal bias_x", bus.bias_x_out, 4);
    apply(1'b1, 0, 0, 32767, 1'b0);
    chk("sat high gz", bus.gz_out, 32767);
    idle();

    // Reset in the middle of ACCUM.
    apply(1'b0, 0, 0, 0, 1'b1);
    apply(1'b1, 50, 50, 50, 1'b0);
    apply(1'b1, 50, 50, 50, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst calibrating", {31'd0, bus.calibrating_out}, 0);
    chk("mid rst bias_z", bus.bias_z_out, 0);
    chk("mid rst bias_x", bus.bias_x_out, 0);
    rst_n = 1'b1;
    apply(1'b1, 300, -300, 1, 1'b0);
    chk("post rst gx", bus.gx_out, 300);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gyro_bias_cal.md
# gyro_bias_cal

Calibration and bias-removal stage between the MPU-6050 I2C reader and the gyro integrator. On request it averages 2^LOG2_SAMPLES consecutive gyro samples per axis into a per-axis zero-rate bias. It then subtracts that bias, with saturation, from every subsequent sample before the integrator sees it. This replaces the ad-hoc averaging logic in the top level and gives the integrator drift-free input.

## Interface
Parameters:
- LOG2_SAMPLES, 10: log2 of the number of samples averaged per calibration (1..16).
- DEADBAND, 8: magnitude, in raw LSB, at or below which corrected output is forced to 0 (used only with GYRO_DEADBAND_EN).

Ports:
- clk_in  input  1  system clock (clk_100mhz domain).
- rst_n_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  one-cycle strobe: gx_in/gy_in/gz_in hold a new sample.
- gx_in, gy_in, gz_in  input  16 each  raw signed angular rate.
- cal_start_in  input  1  one-cycle pulse that starts or restarts calibration.
- gx_out, gy_out, gz_out  output  16 each  signed, bias-corrected, saturated rate.
- valid_out  output  1  strobe that qualifies the *_out rate values.
- bias_x_out, bias_y_out, bias_z_out  output  16 each  current signed bias.
- calibrating_out  output  1  high while in ACCUM or LATCH.
- cal_done_out  output  1  one-cycle pulse when a new bias is committed.

## Operation
FSM states are IDLE, ACCUM, LATCH and CALIBRATED.
- IDLE (reset state): bias = 0, so samples pass through unchanged. cal_start_in moves to ACCUM and clears the accumulators and sample counter.
- ACCUM: each valid_in adds the sign-extended sample into a per-axis signed accumulator of width 16+LOG2_SAMPLES and increments the counter. When the counter reaches 2^LOG2_SAMPLES (the final sample accepted), move to LATCH.
- LATCH (one cycle): bias_* <= accumulator >>> LOG2_SAMPLES (arithmetic shift, rounds toward −∞). Pulse cal_done_out, then go to CALIBRATED.
- CALIBRATED: hold bias. cal_start_in returns to ACCUM with cleared accumulators and counter.
- cal_start_in in ACCUM or LATCH restarts the calibration: counter and accumulators clear, state goes to ACCUM, bias is unchanged and cal_done_out does not pulse.
- Correction runs in every state and uses the currently committed bias: out = sat16(in − bias), computed at 17 bits and clamped to [−32768, 32767].
- A sample coincident with cal_start_in is corrected and output, but it is not accumulated. Accumulation begins with the next valid_in.
- A sample arriving in the LATCH cycle is corrected with the old bias.
- Reset mid-calibration returns to IDLE with bias = 0.

## Timing
- Reset values: all *_out = 0, valid_out = 0, calibrating_out = 0, cal_done_out = 0, state = IDLE.
- valid_out asserts exactly 1 cycle after valid_in. gx/gy/gz_out are registered and stay stable until the next valid_out.
- Back-to-back valid_in on consecutive cycles is supported at full throughput.
- cal_done_out and the new bias_* appear in the cycle after LATCH is entered, which is 2 cycles after the final accumulated valid_in.
- calibrating_out follows the state register, with no extra latency.

## Configuration
- GYRO_DEADBAND_EN defined: after saturation, any axis with |out| ≤ DEADBAND outputs 0. This adds one comparison per axis with no extra latency.
- GYRO_DEADBAND_EN undefined: no deadband logic is present and the outputs are the plain saturated difference.

## Structure
- Shared package gyro_pkg holds:
  - the FSM enum type gyro_cal_state_t;
  - localparam GYRO_W = 16;
  - the saturating function sat16.
- One sub-module, gyro_axis_cal, implements per-axis accumulation, bias register and correction/saturation. It is instantiated three times; the top of this block owns the FSM and the counter.

## Test plan
- Pass-through: after reset, valid_in with gx = 100, gy = −50, gz = 0 → one cycle later valid_out = 1 with the same values, and bias = 0.
- Calibration: with LOG2_SAMPLES = 2, pulse cal_start_in, then send 4 samples of gx = 10, 12, 14, 16 → cal_done_out pulses 2 cycles after the 4th sample, bias_x = 13, and a next input gx = 20 gives gx_out = 7.
- Negative rounding: with LOG2_SAMPLES = 2, calibrate on gy = −1, −1, −1, −2 → bias_y = −2 (shift rounds toward −∞).
- Saturation: with bias_z = 100 committed, input gz = −32768 → gz_out = −32768; with bias_z = −100, input gz = 32767 → gz_out = 32767.
- Restart and reset: cal_start_in after 2 of 4 samples → counter restarts, bias unchanged, and 4 further samples are needed. Asserting rst_n_in = 0 mid-ACCUM → IDLE, bias = 0, calibrating_out = 0.
- With GYRO_DEADBAND_EN and DEADBAND = 8: corrected value 8 → output 0, and corrected value 9 → output 9.
